// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: load-miss refill and write-through store controller that
// sits between the memory stage, a 2-way data cache and main memory.
// Load hits complete combinationally. Load misses and stores stall the pipeline
// while a single word moves over the memory request/response channel.
// Hit and miss counters are kept for performance measurement.
module dcache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic [DATA_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_we,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS_REQ   = 3'd1,
    MISS_WAIT  = 3'd2,
    STORE_REQ  = 3'd3,
    STORE_WAIT = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   fill_q;
  // Set when the access that reaches DONE was a load miss, so DONE returns fill_q.
  logic                    fill_sel_q;
  logic [CNT_WIDTH-1:0]    hit_q;
  logic [CNT_WIDTH-1:0]    miss_q;

  logic load_hit;
  logic load_miss;
  logic store;

  assign load_hit  = cpu_req & ~cpu_we & cache_hit;
  assign load_miss = cpu_req & ~cpu_we & ~cache_hit;
  assign store     = cpu_req & cpu_we;

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign mem_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata  = wdata_q;

  // State sequencing, request latching and performance counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      fill_sel_q <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hit) begin
            hit_q <= hit_q + CNT_ONE;
          end else if (load_miss) begin
            addr_q <= cpu_addr;
            miss_q <= miss_q + CNT_ONE;
            state  <= MISS_REQ;
          end else if (store) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            state   <= STORE_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            fill_q     <= mem_resp_data;
            fill_sel_q <= 1'b1;
            state      <= DONE;
          end
        end
        STORE_REQ: begin
          if (mem_req_ready) state <= STORE_WAIT;
        end
        STORE_WAIT: begin
          if (mem_resp_valid) begin
            fill_sel_q <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; IDLE outputs are held inactive while reset is asserted so
  // a request left on the bus cannot raise stall or a cache write.
  always_comb begin
    stall         = 1'b0;
    cache_we      = 1'b0;
    cache_wdata   = cpu_wdata;
    cache_addr    = addr_q;
    cpu_rdata     = cache_rdata;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    case (state)
      IDLE: begin
        cache_addr = cpu_addr;
        if (rst_n) begin
          stall    = load_miss | store;
          cache_we = store;
        end
      end
      MISS_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      MISS_WAIT: begin
        stall       = 1'b1;
        cache_we    = mem_resp_valid;
        cache_wdata = mem_resp_data;
      end
      STORE_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
      end
      STORE_WAIT: begin
        stall = 1'b1;
      end
      DONE: begin
        if (fill_sel_q) cpu_rdata = fill_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule
